// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one byte-wide flash read engine between two
// burst requesters, with a per-access timeout.
module flash_read_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int LEN_W   = 9,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*LEN_W-1:0]    req_len,
    output logic [1:0]            gnt,
    output logic [1:0]            byte_valid,
    output logic [7:0]            byte_data,
    input  logic [1:0]            byte_ready,
    output logic [1:0]            done,
    output logic                  err,
    output logic                  rd_read,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic                  rd_ready,
    input  logic [7:0]            rd_data
);

    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        FIN
    } state_t;

    state_t            state;
    logic              last;
    logic              gidx;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic [TW-1:0]     timer;

    logic              pick;
    logic [1:0]        pick_oh;
    logic [1:0]        g_oh;
    logic [ADDR_W-1:0] win_addr;
    logic [LEN_W-1:0]  win_len;
    logic [ADDR_W-1:0] next_addr;
    logic              accept;

    // Requester 1 wins when alone, or on contention when 0 was served last.
    assign pick      = req[1] & (~req[0] | ~last);
    assign pick_oh   = pick ? 2'b10 : 2'b01;
    assign g_oh      = gidx ? 2'b10 : 2'b01;
    assign win_addr  = pick ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
    assign win_len   = pick ? req_len[LEN_W +: LEN_W] : req_len[0 +: LEN_W];
    assign next_addr = cur_addr + ADDR_W'(1);
    assign accept    = |(byte_ready & g_oh);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            gidx       <= 1'b0;
            cur_addr   <= '0;
            remaining  <= '0;
            timer      <= '0;
            gnt        <= '0;
            byte_valid <= '0;
            byte_data  <= '0;
            done       <= '0;
            err        <= 1'b0;
            rd_read    <= 1'b0;
            rd_addr    <= '0;
        end else begin
            rd_read <= 1'b0;
            done    <= '0;
            err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gidx      <= pick;
                        gnt       <= pick_oh;
                        cur_addr  <= win_addr;
                        remaining <= win_len;
                        if (win_len == LEN_W'(0)) begin
                            done  <= pick_oh;
                            state <= FIN;
                        end else begin
                            rd_read <= 1'b1;
                            rd_addr <= win_addr;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion arriving on the timeout cycle still counts.
                    if (rd_ready) begin
                        byte_data  <= rd_data;
                        byte_valid <= g_oh;
                        state      <= HOLD;
                    end else if (timer == TW'(TIMEOUT)) begin
                        done  <= g_oh;
                        err   <= 1'b1;
                        state <= FIN;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                HOLD: begin
                    if (accept) begin
                        byte_valid <= '0;
                        cur_addr   <= next_addr;
                        remaining  <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            done  <= g_oh;
                            state <= FIN;
                        end else begin
                            rd_read <= 1'b1;
                            rd_addr <= next_addr;
                            state   <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    gnt   <= '0;
                    last  <= gidx;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a latency-programmable
// flash reader model returning 0xA0 + addr[7:0].
module tb_flash_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [47:0] req_addr;
    logic [17:0] req_len;
    logic [1:0]  gnt;
    logic [1:0]  byte_valid;
    logic [7:0]  byte_data;
    logic [1:0]  byte_ready;
    logic [1:0]  done;
    logic        err;
    logic        rd_read;
    logic [23:0] rd_addr;
    logic        rd_ready = 1'b0;
    logic [7:0]  rd_data = 8'h00;

    int total = 0;
    int bad = 0;

    logic [7:0]  bq[$];
    logic [23:0] aq[$];
    int rd_cnt = 0;
    int done_cnt = 0;
    int both_cnt = 0;

    bit          rd_en = 1'b1;
    int          lat = 2;
    bit          stray = 1'b0;
    int          pend = 0;
    logic [23:0] lat_addr = '0;

    int b0, a0, d0, rc, bc, dc;

    flash_read_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .gnt       (gnt),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .done      (done),
        .err       (err),
        .rd_read   (rd_read),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    // Flash reader: answers each strobe after lat cycles unless disabled.
    always @(negedge clk) begin
        rd_ready = stray;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                rd_ready = 1'b1;
                rd_data  = 8'hA0 + lat_addr[7:0];
            end
        end
        if (rd_read && rd_en) begin
            pend     = lat;
            lat_addr = rd_addr;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if ((byte_valid & byte_ready) != 2'b00) bq.push_back(byte_data);
            if (rd_read) begin
                aq.push_back(rd_addr);
                rd_cnt++;
            end
            if (done != 2'b00) done_cnt++;
            if (gnt == 2'b11) both_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(input string tag, input logic [1:0] exp);
        int k = 0;
        while (gnt == 2'b00 && k < 50) begin
            tick(1);
            k++;
        end
        chk(tag, gnt, exp);
    endtask

    task automatic wait_valid(input string tag, input logic [1:0] exp);
        int k = 0;
        while (byte_valid == 2'b00 && k < 50) begin
            tick(1);
            k++;
        end
        chk(tag, byte_valid, exp);
    endtask

    task automatic wait_done(input string tag, input logic [1:0] exp_d,
                             input logic exp_e);
        int k = 0;
        while (done == 2'b00 && k < 2000) begin
            tick(1);
            k++;
        end
        chk(tag, {done, err}, {exp_d, exp_e});
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00;
        byte_ready = 2'b00;
        req_addr = '0;
        req_len = '0;
        tick(3);
        chk("rst_ctl", {gnt, byte_valid, done, err, rd_read}, 0);
        chk("rst_data", {byte_data, rd_addr}, 0);
        rst = 1'b0;

        // Single burst of 4
        byte_ready = 2'b11;
        req_addr[23:0] = 24'h400000;
        req_len[8:0] = 9'd4;
        b0 = bq.size();
        a0 = aq.size();
        d0 = done_cnt;
        req = 2'b01;
        tick(1);
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_rd_read", rd_read, 1);
        chk("t1_rd_addr", rd_addr, 24'h400000);
        req = 2'b00;
        wait_done("t1_done", 2'b01, 1'b0);
        chk("t1_nbytes", bq.size() - b0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_byte", bq[b0+i], 8'hA0 + i);
            chk("t1_raddr", aq[a0+i], 24'h400000 + i);
        end
        tick(1);
        chk("t1_gnt_off", gnt, 2'b00);
        chk("t1_done_cnt", done_cnt - d0, 1);

        // Round-robin contention from reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        req_addr = {24'h000210, 24'h000100};
        req_len = {9'd2, 9'd2};
        bc = both_cnt;
        b0 = bq.size();
        req = 2'b11;
        wait_gnt("t2_g0", 2'b01);
        wait_done("t2_d0", 2'b01, 1'b0);
        tick(1);
        chk("t2_gap0", gnt, 2'b00);
        tick(1);
        chk("t2_g1", gnt, 2'b10);
        wait_done("t2_d1", 2'b10, 1'b0);
        tick(2);
        chk("t2_g2", gnt, 2'b01);
        wait_done("t2_d2", 2'b01, 1'b0);
        tick(2);
        chk("t2_g3", gnt, 2'b10);
        req = 2'b00;
        wait_done("t2_d3", 2'b10, 1'b0);
        chk("t2_never_both", both_cnt - bc, 0);
        chk("t2_b0", bq[b0], 8'hA0);
        chk("t2_b1", bq[b0+1], 8'hA1);
        chk("t2_b2", bq[b0+2], 8'hB0);
        chk("t2_b3", bq[b0+3], 8'hB1);

        // Backpressure on byte 2
        tick(1);
        byte_ready = 2'b00;
        req_addr[23:0] = 24'h000020;
        req_len[8:0] = 9'd3;
        b0 = bq.size();
        req = 2'b01;
        wait_gnt("t3_gnt", 2'b01);
        req = 2'b00;
        wait_valid("t3_v1", 2'b01);
        chk("t3_d1", byte_data, 8'hC0);
        byte_ready = 2'b01;
        tick(1);
        chk("t3_rd_after_acc", rd_read, 1);
        byte_ready = 2'b10;
        wait_valid("t3_v2", 2'b01);
        rc = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_v", byte_valid, 2'b01);
            chk("t3_hold_d", byte_data, 8'hC1);
            tick(1);
        end
        chk("t3_no_rd", rd_cnt - rc, 0);
        byte_ready = 2'b01;
        tick(1);
        byte_ready = 2'b00;
        wait_valid("t3_v3", 2'b01);
        chk("t3_d3", byte_data, 8'hC2);
        byte_ready = 2'b01;
        wait_done("t3_done", 2'b01, 1'b0);
        chk("t3_nbytes", bq.size() - b0, 3);
        byte_ready = 2'b11;

        // Timeout: reader silent
        tick(1);
        rd_en = 1'b0;
        req_addr[23:0] = 24'h000050;
        req_len[8:0] = 9'd2;
        req = 2'b01;
        tick(1);
        chk("t4_issue", {gnt, rd_read}, 3'b011);
        req = 2'b00;
        tick(1);
        tick(255);
        chk("t4_early", done, 2'b00);
        tick(1);
        chk("t4_to", {done, err}, 3'b011);
        tick(1);
        chk("t4_gnt_off", {gnt, err}, 0);
        rd_en = 1'b1;
        req_addr[23:0] = 24'h000005;
        req_len[8:0] = 9'd1;
        req = 2'b01;
        wait_gnt("t4_regnt", 2'b01);
        req = 2'b00;
        wait_done("t4_redone", 2'b01, 1'b0);
        chk("t4_rebyte", bq[bq.size()-1], 8'hA5);

        // Address wrap on requester 1, then len=0
        tick(1);
        req_addr[47:24] = 24'hFFFFFE;
        req_len[17:9] = 9'd3;
        a0 = aq.size();
        b0 = bq.size();
        req = 2'b10;
        wait_gnt("t5_gnt", 2'b10);
        req = 2'b00;
        wait_done("t5_done", 2'b10, 1'b0);
        chk("t5_a0", aq[a0], 24'hFFFFFE);
        chk("t5_a1", aq[a0+1], 24'hFFFFFF);
        chk("t5_a2", aq[a0+2], 24'h000000);
        chk("t5_b0", bq[b0], 8'h9E);
        chk("t5_b1", bq[b0+1], 8'h9F);
        chk("t5_b2", bq[b0+2], 8'hA0);
        tick(1);
        req_len[8:0] = 9'd0;
        rc = rd_cnt;
        req = 2'b01;
        tick(1);
        chk("t5_len0", {gnt, done}, 4'b0101);
        chk("t5_len0_rd", rd_read, 0);
        req = 2'b00;
        tick(1);
        chk("t5_len0_off", gnt, 2'b00);
        tick(3);
        chk("t5_len0_nrd", rd_cnt - rc, 0);

        // Reset mid-burst
        byte_ready = 2'b00;
        req_addr[23:0] = 24'h000030;
        req_len[8:0] = 9'd5;
        req = 2'b01;
        wait_gnt("t6_gnt", 2'b01);
        req = 2'b00;
        wait_valid("t6_v1", 2'b01);
        byte_ready = 2'b01;
        tick(1);
        byte_ready = 2'b00;
        wait_valid("t6_v2", 2'b01);
        dc = done_cnt;
        rst = 1'b1;
        tick(1);
        chk("t6_rst_ctl", {gnt, byte_valid, done, err, rd_read}, 0);
        chk("t6_rst_data", {byte_data, rd_addr}, 0);
        rst = 1'b0;
        stray = 1'b1;
        tick(2);
        stray = 1'b0;
        tick(1);
        chk("t6_stray", {gnt, byte_valid, rd_read}, 0);
        chk("t6_no_done", done_cnt - dc, 0);
        req_len = {9'd1, 9'd1};
        req = 2'b11;
        tick(1);
        chk("t6_fresh", gnt, 2'b01);
        req = 2'b00;
        byte_ready = 2'b11;
        wait_done("t6_done", 2'b01, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
